// File: rtl/mcdt_pkg.sv
// Shared constants and width helpers for the multi-channel merge stage.
package mcdt_pkg;

    // Arbitration mode selectors for the ARB_MODE parameter.
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Width of the source-channel id; never narrower than one bit.
    function automatic int calc_idw(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Width of a FIFO occupancy/margin value; must represent 0..DEPTH.
    function automatic int calc_mw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mcdt_arb_if.sv
// Channel-side and output-side signals of the merge stage.
// Handshake: a channel word is taken on a rising edge where ch_valid_i[k] and
// ch_ready_o[k] are both high; an output word is taken on a rising edge where
// mcdt_val_o and mcdt_ready_i are both high, and while mcdt_val_o is high
// without mcdt_ready_i, mcdt_data_o and mcdt_id_o hold their values.
interface mcdt_arb_if
    import mcdt_pkg::*;
#(
    parameter int DW    = 32,
    parameter int NCH   = 4,
    parameter int DEPTH = 16
);
    localparam int IDW = calc_idw(NCH);
    localparam int MW  = calc_mw(DEPTH);

    logic [NCH*DW-1:0] ch_data_i;
    logic [NCH-1:0]    ch_valid_i;
    logic [NCH-1:0]    ch_ready_o;
    logic [NCH*MW-1:0] ch_margin_o;
    logic [NCH-1:0]    ch_en_i;
    logic [DW-1:0]     mcdt_data_o;
    logic              mcdt_val_o;
    logic [IDW-1:0]    mcdt_id_o;
    logic              mcdt_ready_i;

    // Seen from the merge stage.
    modport slave (
        input  ch_data_i, ch_valid_i, ch_en_i, mcdt_ready_i,
        output ch_ready_o, ch_margin_o, mcdt_data_o, mcdt_val_o, mcdt_id_o
    );

    // Seen from the channel sources and downstream consumer.
    modport master (
        output ch_data_i, ch_valid_i, ch_en_i, mcdt_ready_i,
        input  ch_ready_o, ch_margin_o, mcdt_data_o, mcdt_val_o, mcdt_id_o
    );
endinterface

// File: rtl/mcdt_chnl_fifo.sv
// One synchronous per-channel FIFO with occupancy count and free-entry margin.
// The read side is show-ahead: rd_data_o is the head word whenever not empty.
module mcdt_chnl_fifo
    import mcdt_pkg::*;
#(
    parameter  int DW    = 32,
    parameter  int DEPTH = 16,
    localparam int MW    = calc_mw(DEPTH),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_valid_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_ready_o,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          empty_o,
    output logic [MW-1:0] margin_o
);
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [MW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          full;
    logic          wr_fire;
    logic          rd_fire;

    assign full       = (count_q == MW'(DEPTH));
    assign empty_o    = (count_q == '0);
    // Ready comes from the registered count only, and is held low in reset.
    assign wr_ready_o = !full && !rst_i;
    assign wr_fire    = wr_valid_i && !full;
    assign rd_fire    = rd_en_i && !empty_o;
    assign margin_o   = MW'(DEPTH) - count_q;
    assign rd_data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + MW'(wr_fire) - MW'(rd_fire);
    end

    // Control state; contents become unreachable when pointers reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written at the write pointer.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/mcdt_arb.sv
// Channel-merge stage: NCH FIFOs feeding one registered output through a
// fixed-priority or round-robin arbiter, with valid/ready backpressure.
module mcdt_arb
    import mcdt_pkg::*;
#(
    parameter int DW       = 32,
    parameter int NCH      = 4,
    parameter int DEPTH    = 16,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic       clk_i,
    input  logic       rst_i,
    mcdt_arb_if.slave  bus
);
    localparam int IDW = calc_idw(NCH);
    localparam int MW  = calc_mw(DEPTH);

    logic [DW-1:0]     head [NCH];
    logic [NCH-1:0]    empty;
    logic [NCH-1:0]    eligible;
    logic [NCH-1:0]    pop;
    logic [NCH-1:0]    ready_v;
    logic [NCH*MW-1:0] margin_v;

    logic              grant_vld;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    cand;
    logic              out_free;

    logic              val_q, val_d;
    logic [DW-1:0]     data_q, data_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [IDW-1:0]    last_q, last_d;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        mcdt_chnl_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .wr_valid_i (bus.ch_valid_i[k]),
            .wr_data_i  (bus.ch_data_i[k*DW +: DW]),
            .wr_ready_o (ready_v[k]),
            .rd_en_i    (pop[k]),
            .rd_data_o  (head[k]),
            .empty_o    (empty[k]),
            .margin_o   (margin_v[k*MW +: MW])
        );
    end

    // Disabled channels keep filling; they are only hidden from the arbiter.
    assign eligible = ~empty & bus.ch_en_i;

    // Grant search: from index 0 in fixed mode, from last+1 in round-robin.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ARB_MODE == ARB_RR) cand = IDW'((int'(last_q) + 1 + i) % NCH);
            else                    cand = IDW'(i);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Output register: reload only when empty or being drained this cycle.
    always_comb begin
        out_free = !val_q || bus.mcdt_ready_i;
        val_d    = val_q;
        data_d   = data_q;
        id_d     = id_q;
        last_d   = last_q;
        pop      = '0;
        if (out_free) val_d = grant_vld;
        if (out_free && grant_vld) begin
            data_d         = head[grant_idx];
            id_d           = grant_idx;
            last_d         = grant_idx;
            pop[grant_idx] = 1'b1;
        end
    end

    // Output word and round-robin pointer; pointer resets so channel 0 wins first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            val_q  <= 1'b0;
            data_q <= '0;
            id_q   <= '0;
            last_q <= IDW'(NCH - 1);
        end else begin
            val_q  <= val_d;
            data_q <= data_d;
            id_q   <= id_d;
            last_q <= last_d;
        end
    end

    assign bus.ch_ready_o  = ready_v;
    assign bus.ch_margin_o = margin_v;
    assign bus.mcdt_val_o  = val_q;
    assign bus.mcdt_data_o = data_q;
    assign bus.mcdt_id_o   = id_q;
endmodule

// File: tb/tb_mcdt_arb.sv
// Directed bench for mcdt_arb: a round-robin instance and a fixed-priority
// instance, with an expected-word queue checked as words leave the output.
module tb_mcdt_arb;
    localparam int DW = 32;
    localparam int NCH = 4;
    localparam int DEPTH = 16;
    localparam int MW = 5;
    localparam logic [NCH*MW-1:0] ALL_EMPTY = {NCH{5'd16}};

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_valid;
    logic [NCH-1:0]    ch_en;
    logic              ready;
    logic              use_fx;

    mcdt_arb_if #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH)) r_if ();
    mcdt_arb_if #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH)) f_if ();

    assign r_if.ch_data_i    = ch_data;
    assign r_if.ch_valid_i   = use_fx ? '0 : ch_valid;
    assign r_if.ch_en_i      = ch_en;
    assign r_if.mcdt_ready_i = use_fx ? 1'b0 : ready;
    assign f_if.ch_data_i    = ch_data;
    assign f_if.ch_valid_i   = use_fx ? ch_valid : '0;
    assign f_if.ch_en_i      = ch_en;
    assign f_if.mcdt_ready_i = use_fx ? ready : 1'b0;

    mcdt_arb #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .ARB_MODE(1)) u_rr (
        .clk_i (clk), .rst_i (rst), .bus (r_if.slave));
    mcdt_arb #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .ARB_MODE(0)) u_fx (
        .clk_i (clk), .rst_i (rst), .bus (f_if.slave));

    logic              mon_val;
    logic [DW-1:0]     mon_data;
    logic [1:0]        mon_id;
    logic [NCH-1:0]    mon_rdy;
    logic [NCH*MW-1:0] mon_margin;
    assign mon_val    = use_fx ? f_if.mcdt_val_o  : r_if.mcdt_val_o;
    assign mon_data   = use_fx ? f_if.mcdt_data_o : r_if.mcdt_data_o;
    assign mon_id     = use_fx ? f_if.mcdt_id_o   : r_if.mcdt_id_o;
    assign mon_rdy    = use_fx ? f_if.ch_ready_o  : r_if.ch_ready_o;
    assign mon_margin = use_fx ? f_if.ch_margin_o : r_if.ch_margin_o;

    // Scoreboard
    logic [33:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] margin_of(input int ch);
        return mon_margin[ch*MW +: MW];
    endfunction

    task automatic sb_pop(input string tag);
        logic [33:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_unexpected: observed id %0d data %0h expected no word", tag, mon_id, mon_data);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_id"}, 64'(mon_id), 64'(e[33:32]));
            check({tag, "_data"}, 64'(mon_data), 64'(e[31:0]));
        end
    endtask

    // Drivers: every step starts and ends on a falling edge.
    task automatic wr(input int ch, input logic [DW-1:0] d);
        ch_valid = '0;
        ch_valid[ch] = 1'b1;
        ch_data = '0;
        ch_data[ch*DW +: DW] = d;
        @(negedge clk);
        ch_valid = '0;
    endtask

    task automatic push_exp(input int ch, input logic [DW-1:0] d);
        exp_q.push_back({2'(ch), d});
    endtask

    task automatic drain(input int n, input string tag);
        int got = 0;
        ready = 1'b1;
        for (int cyc = 0; cyc < n * 4 + 20 && got < n; cyc++) begin
            if (mon_val) begin
                sb_pop(tag);
                got++;
            end
            if (got < n) @(negedge clk);
        end
        check({tag, "_count"}, 64'(got), 64'(n));
        @(negedge clk);
        check({tag, "_idle"}, 64'(mon_val), 64'(0));
        ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ch_data = '0;
        ch_valid = '0;
        ch_en = '1;
        ready = 1'b0;
        use_fx = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ch_ready", 64'(mon_rdy), 64'(0));
        check("rst_margin", 64'(mon_margin), 64'(ALL_EMPTY));
        check("rst_val", 64'(mon_val), 64'(0));
        check("rst_data", 64'(mon_data), 64'(0));
        check("rst_id", 64'(mon_id), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ch_ready", 64'(mon_rdy), 64'hF);

        // Single word: visible two edges after valid is presented
        ready = 1'b1;
        push_exp(0, 32'h00C0_0000);
        wr(0, 32'h00C0_0000);
        check("single_lat1_val", 64'(mon_val), 64'(0));
        @(negedge clk);
        check("single_lat2_val", 64'(mon_val), 64'(1));
        sb_pop("single");
        check("single_margin0", 64'(margin_of(0)), 64'(16));
        @(negedge clk);
        check("single_after_val", 64'(mon_val), 64'(0));
        ready = 1'b0;

        // Fill ch2 while it is disabled, so nothing leaves it
        ch_en = 4'b1011;
        for (int i = 0; i < 17; i++) begin
            if (i == 15) check("fill_ready_before_last", 64'(mon_rdy[2]), 64'(1));
            if (i == 16) begin
                check("fill_ready_full", 64'(mon_rdy[2]), 64'(0));
                check("fill_margin_full", 64'(margin_of(2)), 64'(0));
            end
            if (i < 16) push_exp(2, 32'h2200_0000 + 32'(i));
            wr(2, 32'h2200_0000 + 32'(i));
        end
        check("fill_17th_not_taken", 64'(margin_of(2)), 64'(0));
        check("fill_val_while_disabled", 64'(mon_val), 64'(0));
        ch_en = 4'b1111;
        drain(16, "fill");
        check("fill_ready_restored", 64'(mon_rdy), 64'hF);

        // Round-robin: 3 words per channel
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < NCH; c++) begin
                push_exp(c, 32'hA000_0000 | 32'(c << 8) | 32'(r));
                wr(c, 32'hA000_0000 | 32'(c << 8) | 32'(r));
            end
        drain(12, "rr");

        // Backpressure: held word stays stable
        wr(0, 32'hB000_0000);
        wr(0, 32'hB000_0001);
        wr(0, 32'hB000_0002);
        wr(1, 32'hB000_0103);
        wr(1, 32'hB000_0104);
        wr(3, 32'hB000_0305);
        for (int i = 0; i < 5; i++) begin
            check("bp_val", 64'(mon_val), 64'(1));
            check("bp_data", 64'(mon_data), 64'hB000_0000);
            check("bp_id", 64'(mon_id), 64'(0));
            @(negedge clk);
        end
        // Enable: ch1 is skipped while disabled
        push_exp(0, 32'hB000_0000);
        push_exp(3, 32'hB000_0305);
        push_exp(0, 32'hB000_0001);
        push_exp(0, 32'hB000_0002);
        ch_en = 4'b1101;
        drain(4, "en_off");
        repeat (3) @(negedge clk);
        check("en_off_margin1", 64'(margin_of(1)), 64'(14));
        check("en_off_val", 64'(mon_val), 64'(0));
        push_exp(1, 32'hB000_0103);
        push_exp(1, 32'hB000_0104);
        ch_en = 4'b1111;
        drain(2, "en_on");
        check("en_on_margin1", 64'(margin_of(1)), 64'(16));

        // Fixed priority on the second instance
        use_fx = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < NCH; c++)
                wr(c, 32'hF000_0000 | 32'(c << 8) | 32'(r));
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 3; r++)
                push_exp(c, 32'hF000_0000 | 32'(c << 8) | 32'(r));
        drain(12, "fixed");
        use_fx = 1'b0;
        @(negedge clk);

        // Reset mid-stream with words queued and one held at the output
        wr(0, 32'hD000_0000);
        wr(0, 32'hD000_0001);
        wr(0, 32'hD000_0002);
        wr(1, 32'hD000_0103);
        wr(1, 32'hD000_0104);
        check("mid_rst_pre_val", 64'(mon_val), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_val", 64'(mon_val), 64'(0));
        check("mid_rst_margin", 64'(mon_margin), 64'(ALL_EMPTY));
        check("mid_rst_ready", 64'(mon_rdy), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        push_exp(3, 32'h3300_0033);
        wr(3, 32'h3300_0033);
        drain(1, "post_rst");
        check("post_rst_margin", 64'(mon_margin), 64'(ALL_EMPTY));
        check("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mcdt_arb.md
# mcdt_arb

Parametrised multi-channel data transmitter: NCH input channels, each with a DEPTH-entry FIFO, merged onto one output stream by a fixed-priority or round-robin arbiter. The output has valid/ready backpressure. Each channel can be excluded from arbitration through a per-channel enable. It replaces the fixed 3-channel transmitter as the channel-merge stage between the channel sources and the downstream formatter.

## Interface
- DW, 32, data width
- NCH, 4, channel count (2..16)
- DEPTH, 16, per-channel FIFO depth, power of 2, at least 2
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset; asynchronous and active-high
- ch_data_i  in  NCH*DW  channel data; channel k occupies bits [k*DW +: DW]
- ch_valid_i  in  NCH  channel write request
- ch_ready_o  out  NCH  channel FIFO not full
- ch_margin_o  out  NCH*MW  free entries per channel; MW = $clog2(DEPTH)+1
- ch_en_i  in  NCH  channel is eligible for arbitration
- mcdt_data_o  out  DW  output data
- mcdt_val_o  out  1  output valid
- mcdt_id_o  out  IDW  source channel of mcdt_data_o; IDW = max(1, $clog2(NCH))
- mcdt_ready_i  in  1  downstream accepts

## Operation
- Channel write: occurs when ch_valid_i[k] && ch_ready_o[k]. If valid is high while ready is low, the word is not taken; the source must hold it.
- ch_ready_o[k] = !full[k], taken from the registered count. It is forced to 0 while rst_i is high.
- ch_margin_o[k] = DEPTH − count[k]. It equals DEPTH when the FIFO is empty and 0 when full.
- Eligible channel k: !empty[k] && ch_en_i[k]. Disabled channels still accept writes; they only stop being granted.
- Output register loads when (!mcdt_val_o || mcdt_ready_i) and any channel is eligible:
  - the granted channel's head word is popped;
  - data, id and val = 1 are loaded.
- Output register clears val when it is free and no channel is eligible.
- A word transfers downstream when mcdt_val_o && mcdt_ready_i.
- While val && !ready, data and id stay stable and no pop occurs.
- Fixed priority: the lowest eligible index wins.
- Round-robin:
  - pointer last holds the last granted index; the search starts at last+1 modulo NCH;
  - last updates only on a grant;
  - reset value is NCH−1, so channel 0 wins first.
- Simultaneous write and pop on the same channel: count is unchanged, and the write and read pointers both advance, wrapping modulo DEPTH.
- An empty FIFO is never read; there is no write-to-output bypass.
- Arithmetic:
  - count is MW bits, 0..DEPTH;
  - FIFO pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset values:
  - counts, pointers, mcdt_val_o, mcdt_data_o, mcdt_id_o all 0;
  - ch_ready_o all 0 while rst_i is high, then all 1;
  - ch_margin_o = DEPTH;
  - round-robin pointer = NCH−1.
- Reset mid-operation: all FIFO contents and any held output word are discarded immediately (asynchronous reset). No partial state survives.
- Latency: a word written at edge N with the output free and no competitors gives mcdt_val_o = 1 after edge N+1, i.e. 2 cycles from valid presented.
- Throughput: one word per cycle when mcdt_ready_i is held at 1.
- Full: after the DEPTH-th write with no pops, ch_ready_o[k] goes 0 after that edge. It returns to 1 the cycle after a pop from that channel.
- Toggling ch_en_i takes effect in the same cycle's grant decision.

## Structure
- Package mcdt_pkg holds:
  - the arbitration mode constants ARB_FIXED = 0 and ARB_RR = 1;
  - a function computing IDW and MW from the parameters.
- Sub-module mcdt_chnl_fifo(DW, DEPTH): one synchronous FIFO with count, full/empty and margin. It is instantiated NCH times in a generate loop.
- The top level holds the arbiter, round-robin pointer and output register. Target total RTL is about 200–300 lines.

## Test plan
All scenarios use NCH=4, DEPTH=16, DW=32.
- Single word: write 0x00C0_0000 on ch0 with mcdt_ready_i = 1 -> mcdt_val_o high 2 cycles later, data 0x00C0_0000, id 0; ch_margin_o[0] returns to 16.
- Fill and full: hold mcdt_ready_i = 0 and write 17 words to ch2 -> ch_ready_o[2] = 0 after the 16th write; margin = 0; the 17th word is not taken. Raise ready -> 16 words out in order, id 2.
- Round-robin: ARB_MODE = 1, preload 3 words on each of ch0..ch3, then ready = 1 -> id sequence 0,1,2,3,0,1,2,3,0,1,2,3.
- Fixed priority: ARB_MODE = 0, same preload -> ids 0,0,0,1,1,1,2,2,2,3,3,3.
- Backpressure and enable:
  - drop mcdt_ready_i while a word is valid -> data and id stay stable for 5 cycles;
  - clear ch_en_i[1] with ch1 non-empty -> id 1 never appears, and ch1 margin is unchanged until re-enabled.
- Reset mid-stream: assert rst_i between edges with 5 words queued -> mcdt_val_o drops immediately, all margins = 16. After release, the first new word on ch3 exits with id 3.
